// File: rtl/block_average_downscale.sv
// 2:1 image downscaler: reads a 2*DST_WIDTH x 2*DST_HEIGHT source RAM and writes a DST_WIDTH x DST_HEIGHT result.
// Define DOWNSCALE_AVG_EN for rounded 2x2 block averaging; leave it undefined for plain decimation (top-left pixel).
module block_average_downscale #(
  parameter int DST_WIDTH  = 160,
  parameter int DST_HEIGHT = 120
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [7:0]  PIXEL_IN,
  output logic [16:0] R_ADDR,
  output logic [14:0] W_ADDR,
  output logic [7:0]  PIXEL_OUT,
  output logic        W_EN,
  output logic        BUSY,
  output logic        DONE
);

  localparam int XW = (DST_WIDTH > 1) ? $clog2(DST_WIDTH) : 1;
  localparam int YW = (DST_HEIGHT > 1) ? $clog2(DST_HEIGHT) : 1;

  localparam logic [16:0]   SRC_ROW2 = 17'(4 * DST_WIDTH);
  localparam logic [14:0]   DST_ROW  = 15'(DST_WIDTH);
  localparam logic [XW-1:0] X_LAST   = XW'(DST_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(DST_HEIGHT - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] A0   = 3'd1;
  localparam logic [2:0] LAST = 3'd5;
  localparam logic [2:0] WR   = 3'd6;
  localparam logic [2:0] FIN  = 3'd7;
`ifdef DOWNSCALE_AVG_EN
  localparam logic [2:0] A1   = 3'd2;
  localparam logic [2:0] A2   = 3'd3;
  localparam logic [2:0] A3   = 3'd4;
  // Step from p1 (top-right) down to p2 (bottom-left).
  localparam logic [16:0] P1_TO_P2 = 17'(2 * DST_WIDTH - 1);
`endif

  logic [2:0]    state_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [XW-1:0] x_nxt_s;
  logic [YW-1:0] y_nxt_s;
  logic          last_pix_s;
  logic [16:0]   p0_nxt_s;
  logic [14:0]   w_addr_s;
`ifdef DOWNSCALE_AVG_EN
  logic [9:0]    sum_r;
  logic [9:0]    sum_add_s;
  logic [9:0]    round_s;
`endif

  // Next raster position, its top-left source address and the current write address.
  always_comb begin
    last_pix_s = (x_r == X_LAST) && (y_r == Y_LAST);
    if (x_r == X_LAST) begin
      x_nxt_s = {XW{1'b0}};
      y_nxt_s = y_r + YW'(1);
    end else begin
      x_nxt_s = x_r + XW'(1);
      y_nxt_s = y_r;
    end
    p0_nxt_s = (17'(y_nxt_s) * SRC_ROW2) + 17'({x_nxt_s, 1'b0});
    w_addr_s = (15'(y_r) * DST_ROW) + 15'(x_r);
`ifdef DOWNSCALE_AVG_EN
    sum_add_s = sum_r + {2'b00, PIXEL_IN};
    round_s   = sum_add_s + 10'd2;
`endif
  end

  // Frame sequencer, counters, accumulator and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= IDLE;
      x_r       <= {XW{1'b0}};
      y_r       <= {YW{1'b0}};
`ifdef DOWNSCALE_AVG_EN
      sum_r     <= 10'd0;
`endif
      R_ADDR    <= 17'd0;
      W_ADDR    <= 15'd0;
      PIXEL_OUT <= 8'd0;
      W_EN      <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      W_EN <= 1'b0;
      case (state_r)
        IDLE: begin
          if (START) begin
            state_r <= A0;
            BUSY    <= 1'b1;
            x_r     <= {XW{1'b0}};
            y_r     <= {YW{1'b0}};
            R_ADDR  <= 17'd0;
          end
        end
        A0: begin
`ifdef DOWNSCALE_AVG_EN
          state_r <= A1;
          R_ADDR  <= R_ADDR + 17'd1;
`else
          state_r <= LAST;
`endif
        end
`ifdef DOWNSCALE_AVG_EN
        // PIXEL_IN lags R_ADDR by one cycle, so A1 sees p0 and LAST sees p3.
        A1: begin
          state_r <= A2;
          sum_r   <= {2'b00, PIXEL_IN};
          R_ADDR  <= R_ADDR + P1_TO_P2;
        end
        A2: begin
          state_r <= A3;
          sum_r   <= sum_add_s;
          R_ADDR  <= R_ADDR + 17'd1;
        end
        A3: begin
          state_r <= LAST;
          sum_r   <= sum_add_s;
        end
`endif
        LAST: begin
          state_r   <= WR;
          W_EN      <= 1'b1;
          W_ADDR    <= w_addr_s;
`ifdef DOWNSCALE_AVG_EN
          sum_r     <= sum_add_s;
          PIXEL_OUT <= round_s[9:2];
`else
          PIXEL_OUT <= PIXEL_IN;
`endif
        end
        WR: begin
          if (last_pix_s) begin
            state_r <= FIN;
            x_r     <= {XW{1'b0}};
            y_r     <= {YW{1'b0}};
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
          end else begin
            state_r <= A0;
            x_r     <= x_nxt_s;
            y_r     <= y_nxt_s;
            R_ADDR  <= p0_nxt_s;
          end
        end
        FIN: begin
          state_r <= IDLE;
          DONE    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
        end
      endcase
    end
  end

endmodule
